// File: rtl/button_debouncer_pkg.sv
// ============================================================================
//  Module   : button_debouncer_pkg
//  Brief    : State encoding and default timing constants for button_debouncer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package button_debouncer_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRESS_CHK = 3'd1;
    localparam logic [2:0] ST_HELD      = 3'd2;
    localparam logic [2:0] ST_REPEAT    = 3'd3;
    localparam logic [2:0] ST_REL_CHK   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_PRESS_CHK = ST_PRESS_CHK,
        S_HELD      = ST_HELD,
        S_REPEAT    = ST_REPEAT,
        S_REL_CHK   = ST_REL_CHK
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_EN       = 1;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_PERIOD   = 16;
    localparam int DEF_CNT_W           = 20;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Two-flop synchronizer with synchronous reset to 0.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D_i,
    output logic [WIDTH-1:0] Q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= D_i;
            sync_q <= meta_q;
        end
    end

    assign Q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
//  Module   : button_debouncer
//  Brief    : Push-button debouncer with one En pulse per press, optional
//             auto-repeat while held, and a registered debounced level.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Btn,
    output logic En,
    output logic Level
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit               REPEAT_ON = (REPEAT_EN != 0);

    logic             btn_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] timer_inc;
    logic             timer_clr;
    logic             en_q, en_d;
    logic             level_q, level_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .D_i (Btn),
        .Q_o (btn_s)
    );

    // Saturating increment keeps a long non-repeating hold from wrapping.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        en_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_s) state_d = S_PRESS_CHK;
            end
            S_PRESS_CHK: begin
                if (!btn_s) begin
                    state_d = S_IDLE;
                end else if (timer_q == DEB_LAST) begin
                    state_d = S_HELD;
                    en_d    = 1'b1;
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    state_d = S_REL_CHK;
                end else if (REPEAT_ON && (timer_q == DLY_LAST)) begin
                    state_d = S_REPEAT;
                    en_d    = 1'b1;
                end
            end
            S_REPEAT: begin
                if (!btn_s) begin
                    state_d = S_REL_CHK;
                end else if (timer_q == PER_LAST) begin
                    en_d      = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            S_REL_CHK: begin
                if (btn_s) begin
                    state_d = S_HELD;
                end else if (timer_q == DEB_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        timer_d = ((state_d != state_q) || timer_clr) ? '0 : timer_inc;
        level_d = (state_d == S_HELD) || (state_d == S_REPEAT) || (state_d == S_REL_CHK);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            en_q    <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            // Back-to-back pulses are suppressed even for degenerate delays.
            en_q    <= en_d & ~en_q;
            level_q <= level_d;
        end
    end

    assign En    = en_q;
    assign Level = level_q;

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
//  Module   : tb_button_debouncer
//  Brief    : Self-checking bench for button_debouncer (repeat on and off).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_button_debouncer;

    localparam int DEB  = 16;
    localparam int RDLY = 64;
    localparam int RPER = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic en_r, lvl_r, en_n, lvl_n;

    int total = 0;
    int bad   = 0;
    int tcyc  = 0;

    // Reference model: the debounced level flips after DEB+1 consecutive
    // opposite synchronized samples; repeats fire at h+RDLY+k*RPER where h
    // is the edge at which the current uninterrupted hold began.
    bit m_s1, m_s2, m_lvl, m_en_n, m_en_r;
    int m_run, m_h;
    bit started = 1'b0;

    int qn[$];
    int qr[$];
    int fall_n = -1;
    bit prev_lvl_n = 1'b0;
    bit lo_r = 1'b0;
    int cnt3 = 0;
    bit carry_seen = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEB), .REPEAT_EN (1), .REPEAT_DELAY (RDLY),
        .REPEAT_PERIOD (RPER), .CNT_W (20)
    ) dut_r (
        .Clk (clk), .Rst (rst), .Btn (btn), .En (en_r), .Level (lvl_r)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEB), .REPEAT_EN (0), .REPEAT_DELAY (RDLY),
        .REPEAT_PERIOD (RPER), .CNT_W (20)
    ) dut_n (
        .Clk (clk), .Rst (rst), .Btn (btn), .En (en_n), .Level (lvl_n)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, tcyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit b;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_h = 0;
            m_en_n = 0; m_en_r = 0; started = 1'b1;
        end else begin
            b = m_s2; m_s2 = m_s1; m_s1 = btn;
            m_en_n = 0; m_en_r = 0;
            if (!m_lvl) begin
                if (b) begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        m_lvl = 1; m_run = 0; m_h = tcyc;
                        m_en_n = 1; m_en_r = 1;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (b) begin
                if (m_run > 0) begin
                    m_run = 0; m_h = tcyc;
                end else if ((tcyc - m_h >= RDLY) && ((tcyc - m_h - RDLY) % RPER == 0)) begin
                    m_en_r = 1;
                end
            end else begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl = 0; m_run = 0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            tcyc++;
            model_step();
            @(negedge clk);
            if (started) begin
                check_bit("en_rep",    en_r,  m_en_r);
                check_bit("level_rep", lvl_r, m_lvl);
                check_bit("en_norep",  en_n,  m_en_n);
                check_bit("level_norep", lvl_n, m_lvl);
                if (en_n) begin
                    qn.push_back(tcyc);
                    if (cnt3 == 7) carry_seen = 1'b1;
                    cnt3 = (cnt3 + 1) % 8;
                end
                if (en_r) qr.push_back(tcyc);
                if (prev_lvl_n && !lvl_n) fall_n = tcyc;
                prev_lvl_n = lvl_n;
                if (!lvl_r) lo_r = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int first_off(input int q[$], input int idx, input int base);
        return (q.size() > idx) ? q[idx] - base : -1;
    endfunction

    initial begin
        int n0, m0, len;
        cyc(3);
        check_bit("reset_en",    en_r,  1'b0);
        check_bit("reset_level", lvl_r, 1'b0);
        rst = 1'b0;
        cyc(5);

        // Clean press: one pulse 18 edges after first sample, level falls 18 after release.
        qn.delete(); qr.delete();
        btn = 1'b1; n0 = tcyc + 1;
        cyc(40);
        btn = 1'b0; m0 = tcyc + 1;
        cyc(30);
        check_int("clean_count", qn.size(), 1);
        check_int("clean_latency", first_off(qn, 0, n0), 18);
        check_int("release_latency", fall_n - m0, 18);

        // Bounce: 3-cycle segments 1,0,1,... for 30 cycles, then steady high.
        qn.delete();
        for (int k = 0; k < 10; k++) begin
            btn = (k % 2 == 0);
            cyc(3);
        end
        btn = 1'b1; n0 = tcyc + 1;
        cyc(40);
        check_int("bounce_count", qn.size(), 1);
        check_int("bounce_latency", first_off(qn, 0, n0), 18);
        btn = 1'b0;
        cyc(30);

        // Hold 200: press at +18, then 8 repeats at +82,+98,...,+194.
        qr.delete();
        btn = 1'b1; n0 = tcyc + 1;
        cyc(200);
        btn = 1'b0;
        cyc(40);
        check_int("hold_count", qr.size(), 9);
        check_int("hold_press", first_off(qr, 0, n0), 18);
        for (int i = 1; i < 9; i++) check_int("hold_repeat", first_off(qr, i, n0), 82 + 16 * (i - 1));

        // Release glitch of 10 cycles: hold restarts at +42, next repeat at +106.
        qr.delete();
        btn = 1'b1; n0 = tcyc + 1;
        cyc(30);
        lo_r = 1'b0;
        btn = 1'b0;
        cyc(10);
        btn = 1'b1;
        cyc(80);
        check_bit("glitch_level", lo_r, 1'b0);
        check_int("glitch_count", qr.size(), 2);
        check_int("glitch_repeat", first_off(qr, 1, n0), 106);
        btn = 1'b0;
        cyc(40);

        // Reset at PRESS_CHK timer=10 with the button held.
        qn.delete();
        btn = 1'b1; n0 = tcyc + 1;
        cyc(13);
        rst = 1'b1;
        cyc(1);
        check_bit("midreset_en", en_n, 1'b0);
        check_bit("midreset_level", lvl_n, 1'b0);
        rst = 1'b0; m0 = tcyc + 1;
        cyc(30);
        check_int("midreset_count", qn.size(), 1);
        check_int("midreset_latency", first_off(qn, 0, m0), 18);
        btn = 1'b0;
        cyc(40);

        // Nine presses into a 3-bit count: wraps on the 8th, ends at 1.
        cnt3 = 0; carry_seen = 1'b0;
        for (int p = 0; p < 9; p++) begin
            btn = 1'b1; cyc(25);
            btn = 1'b0; cyc(25);
            if (p == 6) check_bit("count_nocarry7", carry_seen, 1'b0);
            if (p == 7) begin
                check_int("count_after8", cnt3, 0);
                check_bit("carry_on8", carry_seen, 1'b1);
            end
        end
        check_int("count_after9", cnt3, 1);

        // Randomized phase with bounces, long holds and occasional resets.
        repeat (150) begin
            btn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 5);
                1:       len = $urandom_range(100, 200);
                default: len = $urandom_range(1, 40);
            endcase
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; cyc(1); rst = 1'b0;
            end
            cyc(len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
